// File: rtl/gate_deser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_deser_pkg
// Description : Shared types and defaults for the gate-output deserializer.
//               FSM state encoding and default word width.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_deser_pkg;

    // Collector states: waiting for start, packing bits, word on offer.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } deser_state_t;

    localparam int DESER_WIDTH_DEFAULT = 8;

    // Width of a counter that must hold values 0..w inclusive.
    function automatic int deser_cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : gate_deser_pkg
`default_nettype wire

// File: rtl/gate_deser_shreg.sv
`default_nettype none
// ============================================================================
// Module      : gate_deser_shreg
// Description : Datapath of the deserializer: MSB-first shift register, bit
//               counter, ones counter and (with GATE_DESER_PARITY_EN defined)
//               a running parity bit. 'done' flags the cycle in which the
//               last bit of a word is being shifted in.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_deser_shreg
    import gate_deser_pkg::*;
#(
    parameter int WIDTH = DESER_WIDTH_DEFAULT,
    parameter int CW    = deser_cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word,
    output logic [CW-1:0]    ones,
    output logic             done
`ifdef GATE_DESER_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam logic [CW-1:0] c_LAST_IDX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_ones;

    // Shift register and counters; clear wins, counters restart per word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_ones <= '0;
        end else if (clear) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_ones <= '0;
        end else if (shift_en) begin
            r_sh   <= {r_sh[WIDTH-2:0], bit_in};
            r_cnt  <= r_cnt + 1'b1;
            r_ones <= r_ones + {{(CW-1){1'b0}}, bit_in};
        end
    end

`ifdef GATE_DESER_PARITY_EN
    logic r_parity;

    // Running XOR of the sampled bits, kept in step with the ones counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_parity <= 1'b0;
        end else if (clear) begin
            r_parity <= 1'b0;
        end else if (shift_en) begin
            r_parity <= r_parity ^ bit_in;
        end
    end

    assign parity = r_parity;
`endif

    assign word = r_sh;
    assign ones = r_ones;
    // The bit being accepted now is the WIDTH-th one of the word.
    assign done = shift_en && (r_cnt == c_LAST_IDX);

endmodule : gate_deser_shreg
`default_nettype wire

// File: rtl/gate_out_deser.sv
`default_nettype none
// ============================================================================
// Module      : gate_out_deser
// Description : Serial-to-parallel collector for the registered gate output.
//               Packs WIDTH qualified bits (first bit in MSB), counts ones,
//               offers the word on a valid/ready handshake and raises a
//               sticky overrun when bits arrive while a word is pending.
//               Optional feature macro: GATE_DESER_PARITY_EN (adds 'parity').
// Revision    : 1.0 - initial release
// ============================================================================
module gate_out_deser
    import gate_deser_pkg::*;
#(
    parameter int WIDTH = DESER_WIDTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       d_in,
    input  logic                       d_valid,
    input  logic                       start,
    output logic [WIDTH-1:0]           word_out,
    output logic [$clog2(WIDTH+1)-1:0] ones_cnt,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic                       busy,
    output logic                       overrun
`ifdef GATE_DESER_PARITY_EN
    ,
    output logic                       parity
`endif
);

    localparam int c_CW = $clog2(WIDTH + 1);

    deser_state_t r_state;
    deser_state_t w_state_nxt;
    logic         r_overrun;
    logic         w_handshake;
    logic         w_clear;
    logic         w_shift_en;
    logic         w_done;

    assign w_handshake = (r_state == HOLD) && word_ready;
    // Counters restart when a new word begins, either from idle or
    // back-to-back with the handshake of the previous word.
    assign w_clear     = ((r_state == IDLE) && start) || (w_handshake && start);
    assign w_shift_en  = (r_state == SHIFT) && d_valid;

    gate_deser_shreg #(
        .WIDTH (WIDTH),
        .CW    (c_CW)
    ) u_shreg (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (w_clear),
        .shift_en (w_shift_en),
        .bit_in   (d_in),
        .word     (word_out),
        .ones     (ones_cnt),
        .done     (w_done)
`ifdef GATE_DESER_PARITY_EN
        ,
        .parity   (parity)
`endif
    );

    // Next-state selection for the collect / hold cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_done) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_handshake) begin
                    w_state_nxt = start ? SHIFT : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset abandons any partial word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sticky overrun: any qualified bit seen while a word is on offer is
    // lost, including one arriving in the handshake cycle itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if ((r_state == HOLD) && d_valid) begin
            r_overrun <= 1'b1;
        end
    end

    assign word_valid = (r_state == HOLD);
    assign busy       = (r_state != IDLE);
    assign overrun    = r_overrun;

endmodule : gate_out_deser
`default_nettype wire

// File: tb/tb_gate_out_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_out_deser
// Description : Self-checking bench for gate_out_deser (WIDTH=8). Directed
//               scenarios with literal expectations plus randomized traffic
//               compared every cycle against a queue-free arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_out_deser;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk;
    logic          reset_n;
    logic          d_in;
    logic          d_valid;
    logic          start;
    logic [W-1:0]  word_out;
    logic [CW-1:0] ones_cnt;
    logic          word_valid;
    logic          word_ready;
    logic          busy;
    logic          overrun;
`ifdef GATE_DESER_PARITY_EN
    logic          parity;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    gate_out_deser #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .d_in       (d_in),
        .d_valid    (d_valid),
        .start      (start),
        .word_out   (word_out),
        .ones_cnt   (ones_cnt),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .overrun    (overrun)
`ifdef GATE_DESER_PARITY_EN
        ,
        .parity     (parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = not collecting, 1 = collecting bits, 2 = word complete.
    int           m_phase;
    int           m_n;
    int           m_ones;
    int           m_val;
    bit           m_over;
    int           m_words;

    task automatic m_reset();
        m_phase = 0;
        m_n     = 0;
        m_ones  = 0;
        m_val   = 0;
        m_over  = 0;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_reset();
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_n = 0; m_ones = 0; m_val = 0;
                end
                1: if (d_valid) begin
                    m_val  = m_val * 2 + int'(d_in);
                    m_ones = m_ones + int'(d_in);
                    m_n    = m_n + 1;
                    if (m_n == W) m_phase = 2;
                end
                default: begin
                    if (d_valid) m_over = 1;
                    if (word_ready) begin
                        m_words++;
                        if (start) begin
                            m_phase = 1; m_n = 0; m_ones = 0; m_val = 0;
                        end else begin
                            m_phase = 0;
                        end
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("busy", busy, (m_phase != 0));
            chk("word_valid", word_valid, (m_phase == 2));
            chk("overrun", overrun, m_over);
            if (m_phase == 2) begin
                chk("word_out", word_out, m_val);
                chk("ones_cnt", ones_cnt, m_ones);
`ifdef GATE_DESER_PARITY_EN
                chk("parity", parity, m_ones % 2);
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Starts a word (optionally as a back-to-back handshake) and feeds its
    // bits MSB first; returns at the cycle the word should be valid.
    task automatic send_word(input logic [W-1:0] w, input bit gap, input bit hs, output int lat);
        int c0;
        @(negedge clk);
        start = 1'b1; d_valid = 1'b0; word_ready = hs;
        c0 = cyc;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            start = 1'b0; word_ready = 1'b0;
            d_valid = 1'b1; d_in = w[W-1-i];
            if (gap) begin
                @(negedge clk);
                d_valid = 1'b0;
            end
        end
        if (!gap) begin
            @(negedge clk);
            d_valid = 1'b0;
        end
        lat = cyc - c0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_word_out"}, word_out, 0);
        chk({tag, "_ones_cnt"}, ones_cnt, 0);
        chk({tag, "_word_valid"}, word_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_overrun"}, overrun, 0);
`ifdef GATE_DESER_PARITY_EN
        chk({tag, "_parity"}, parity, 0);
`endif
    endtask

    task automatic take_word();
        @(negedge clk); word_ready = 1'b1;
        @(negedge clk); word_ready = 1'b0;
    endtask

    int lat;

    initial begin
        m_words = 0;
        m_reset();
        reset_n = 1'b0; d_in = 1'b0; d_valid = 1'b0; start = 1'b0; word_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // Basic word 1,0,1,1,0,0,1,0 with continuous d_valid.
        send_word(8'hB2, 1'b0, 1'b0, lat);
        chk("basic_lat", lat, 9);
        chk("basic_valid", word_valid, 1);
        chk("basic_word", word_out, 8'hB2);
        chk("basic_ones", ones_cnt, 4);
        chk("model_word", m_val, 8'hB2);
`ifdef GATE_DESER_PARITY_EN
        chk("basic_parity", parity, 0);
`endif

        // Asynchronous reset in the middle of a clock cycle while holding.
        @(posedge clk); #2 reset_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk); reset_n = 1'b1;

        // Gapped input: d_valid low every other cycle.
        send_word(8'hB2, 1'b1, 1'b0, lat);
        chk("gap_lat", lat, 16);
        chk("gap_word", word_out, 8'hB2);
        chk("gap_ones", ones_cnt, 4);
        chk("gap_overrun", overrun, 0);
        take_word();
        chk("gap_valid_drop", word_valid, 0);
        chk("gap_idle", busy, 0);

        // Backpressure with qualified bits arriving while the word waits.
        send_word(8'hFF, 1'b0, 1'b0, lat);
        repeat (5) begin
            @(negedge clk); d_valid = 1'b1; d_in = 1'b0;
        end
        @(negedge clk); d_valid = 1'b0;
        chk("bp_word", word_out, 8'hFF);
        chk("bp_ones", ones_cnt, 8);
        chk("bp_overrun", overrun, 1);
        chk("bp_valid", word_valid, 1);

        // Back-to-back: handshake with start, next word 8'h0F.
        send_word(8'h0F, 1'b0, 1'b1, lat);
        chk("b2b_lat", lat, 9);
        chk("b2b_word", word_out, 8'h0F);
        chk("b2b_ones", ones_cnt, 4);
        chk("b2b_overrun_sticky", overrun, 1);
        take_word();
        chk("b2b_idle", busy, 0);
        chk("b2b_overrun_after", overrun, 1);

        // Reset after three bits of a word, then a fresh word 8'hA5.
        @(negedge clk); start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); start = 1'b0; d_valid = 1'b1; d_in = 1'b1;
        end
        @(posedge clk); #2 reset_n = 1'b0; d_valid = 1'b0;
        #1 check_all_zero("midword_rst");
        @(negedge clk); reset_n = 1'b1;
        send_word(8'hA5, 1'b0, 1'b0, lat);
        chk("a5_lat", lat, 9);
        chk("a5_word", word_out, 8'hA5);
        chk("a5_ones", ones_cnt, 4);
        chk("a5_overrun", overrun, 0);
        take_word();

        // Random traffic that never drives bits while a word is pending.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start      = ($urandom % 4) == 0;
            d_in       = 1'($urandom % 2);
            d_valid    = (m_phase == 2) ? 1'b0 : (($urandom % 4) != 0);
            word_ready = ($urandom % 3) == 0;
        end
        @(negedge clk);
        chk("rand_no_overrun", overrun, 0);

        // Fully random traffic, overruns allowed.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start      = ($urandom % 4) == 0;
            d_in       = 1'($urandom % 2);
            d_valid    = ($urandom % 4) != 0;
            word_ready = ($urandom % 3) == 0;
        end
        @(negedge clk);
        start = 1'b0; d_valid = 1'b0; word_ready = 1'b0;
        chk("rand_words_seen", (m_words > 20), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_gate_out_deser
`default_nettype wire

// File: doc/gate_out_deser.md
# gate_out_deser

Serial-to-parallel collector that sits directly downstream of the registered gate stage. It samples the single-bit registered gate output `D` one bit per qualified cycle, packs `WIDTH` bits into a word, and counts the ones. The word is presented on a valid/ready handshake to the consumer, and an overrun is flagged whenever input bits arrive while a finished word is still waiting to be taken.

## Interface
Parameters:
- `WIDTH`, 8, bits per collected word (≥2)

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `d_in`  in  1  registered gate output `D` from the upstream stage
- `d_valid`  in  1  qualifies `d_in` this cycle
- `start`  in  1  request to begin collecting a new word
- `word_out`  out  WIDTH  collected word; first sampled bit lands in the MSB
- `ones_cnt`  out  $clog2(WIDTH+1)  number of 1 bits in `word_out`
- `word_valid`  out  1  word available
- `word_ready`  in  1  consumer accepts the word
- `busy`  out  1  high in SHIFT and HOLD
- `overrun`  out  1  sticky: a qualified bit was dropped
- `parity`  out  1  XOR of `word_out` (present only when `GATE_DESER_PARITY_EN` is defined)

## Operation
- FSM states: IDLE, SHIFT, HOLD.
- **IDLE**
  - `start=1` → SHIFT; clear the shift register, bit counter and ones counter.
  - `d_valid` is ignored, and no overrun is raised.
- **SHIFT**
  - Each cycle with `d_valid=1`: `sh <= {sh[WIDTH-2:0], d_in}`, the bit counter increments, and the ones counter adds `d_in`.
  - `start` is ignored.
  - When the `WIDTH`-th bit is sampled → HOLD.
- **HOLD**
  - `word_valid=1`; `word_out`, `ones_cnt` and `parity` are stable.
  - Handshake (`word_valid & word_ready`) with `start=1` → SHIFT with counters cleared (back-to-back).
  - Handshake without `start` → IDLE.
  - `d_valid=1` without a handshake in the same cycle: the bit is dropped and `overrun <= 1`.
  - `d_valid=1` in the handshake cycle: the bit is dropped and `overrun` is set, even if `start=1`.
- `overrun` is cleared only by reset.
- Counter widths: the bit counter is $clog2(WIDTH+1) bits and never wraps, because it is cleared on entry to SHIFT. The ones counter has the same width and saturates naturally at `WIDTH`.
- Reset (asynchronous, any state, including mid-SHIFT): state → IDLE. All outputs are 0: `word_out`, `ones_cnt`, `word_valid`, `busy`, `overrun`, `parity`. Partial words are discarded.

## Timing
- `start` sampled in cycle 0 → `busy=1` from cycle 1.
- The first bit can be sampled in cycle 1.
- With continuous `d_valid`, bits are sampled in cycles 1..WIDTH and `word_valid` rises in cycle WIDTH+1 (registered).
- Latency from the last qualified bit to `word_valid` is exactly 1 cycle.
- `word_valid` drops the cycle after the handshake.
- In a back-to-back handshake with `start`, the next bit can be sampled the cycle after the handshake, so the throughput is one word per WIDTH+1 cycles.
- `ones_cnt` and `parity` are valid in the same cycle as `word_valid`; no extra latency.

## Configuration
- `GATE_DESER_PARITY_EN` defined:
  - adds a parity register, updated alongside the ones counter (`parity ^= d_in` per qualified bit, cleared with the counters);
  - adds the output port `parity`.
- Undefined: no parity register and no `parity` port. All other behaviour is identical.

## Structure
- Package `gate_deser_pkg`:
  - `typedef enum logic [1:0] {IDLE, SHIFT, HOLD} deser_state_t`
  - `localparam DESER_WIDTH_DEFAULT = 8`
- One sub-module, `gate_deser_shreg`:
  - contains the shift register, bit counter, ones counter and optional parity;
  - inputs: `shift_en` and `clear`; output: `done`.
- The top level holds the FSM, handshake logic and overrun flag.

## Test plan
All scenarios use WIDTH=8.
1. **Reset:** assert `reset_n=0` mid-clock-cycle → all outputs 0 immediately; state IDLE.
2. **Basic word:** `start` then bits 1,0,1,1,0,0,1,0 with continuous `d_valid` → in cycle 9, `word_valid=1`, `word_out=8'hB2`, `ones_cnt=4`, `parity=0`.
3. **Gapped input:** same bits with `d_valid` low every other cycle → same word, `word_valid` in cycle 16, `overrun=0`.
4. **Backpressure:** after word 8'hFF is complete, hold `word_ready=0` for 5 cycles with `d_valid=1` → `word_out` stays 8'hFF, `ones_cnt=8`, `overrun=1` and remains 1 after the handshake.
5. **Back-to-back:** handshake with `start=1` → `busy` stays high, the next 8 bits 8'h0F yield `word_valid` 9 cycles after the handshake, `ones_cnt=4`, no lost bits.
6. **Reset mid-word:** reset after 3 bits in SHIFT → outputs 0; a fresh `start` plus 8'hA5 → `word_out=8'hA5`, `ones_cnt=4`.
